// File: rtl/mem_stage_pkg.sv
// Shared widths, ld_op codes, FSM states and bus layouts for the MEM stage.
// Bus structs are packed so their first member lands in the MSBs of the flat bus.
package mem_stage_pkg;

  localparam int EX_MEM_W = 188;
  localparam int MEM_WB_W = 184;
  localparam int MEM_ID_W = 40;

  typedef enum logic [2:0] {
    LD_NONE  = 3'd0,
    LD_B     = 3'd1,
    LD_H     = 3'd2,
    LD_W     = 3'd3,
    LD_BU    = 3'd4,
    LD_HU    = 3'd5,
    LD_STORE = 3'd6,
    LD_RSVD  = 3'd7
  } ld_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [2:0]  ld_op;
    logic        req_sent;
    logic        gr_we;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall;
  } ex_mem_t;

  typedef struct packed {
    logic        gr_we;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] final_result;
    logic [4:0]  dest;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall;
  } mem_wb_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        load_pending;
    logic        csr_re;
  } mem_id_t;

  // Only the five real load encodings produce extended data; store/none/reserved pass alu_result.
  function automatic logic is_load(input logic [2:0] op);
    return (op >= LD_B) && (op <= LD_HU);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data extraction: picks the byte/half addressed by addr and sign- or zero-extends it.
// Purely combinational; misaligned ld.h/ld.w never reach here.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (ld_op_e'(ld_op))
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_W:    result = rdata;
      LD_BU:   result = {24'b0, byte_sel};
      LD_HU:   result = {16'b0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from EX, waits for its data-SRAM response,
// extends load data, and drains responses orphaned by a flush.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_mem_valid,
  input  logic [EX_MEM_W-1:0] ex_mem_bus,
  output logic                mem_allowin,
  input  logic                wb_allowin,
  output logic                mem_wb_valid,
  output logic [MEM_WB_W-1:0] mem_wb_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                flush,
  output logic [MEM_ID_W-1:0] mem_id_bus,
  output logic                mem_ex_block,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where the producer's valid and
  // the consumer's allowin are both high; valid/bus stay stable until then.

  ex_mem_t    ex_in;
  ex_mem_t    cur;
  mem_wb_t    wb;
  mem_id_t    id;
  mem_state_e state;
  logic       mem_valid;
  logic [31:0] rdata_buf;

  logic        need_data;
  logic        mem_ready_go;
  logic        accept;
  logic        take_req;
  logic        cur_is_load;
  logic [31:0] ld_src;
  logic [31:0] load_val;
  logic [31:0] final_result;

  assign ex_in = ex_mem_bus;

  assign need_data    = mem_valid & cur.req_sent;
  assign mem_ready_go = (state != ST_DISCARD) &
                        (~need_data | data_sram_data_ok | (state == ST_HOLD));
  assign mem_allowin  = (state != ST_DISCARD) & (~mem_valid | (mem_ready_go & wb_allowin));
  assign mem_wb_valid = mem_valid & mem_ready_go & ~flush;

  assign accept   = mem_allowin & ex_mem_valid;
  assign take_req = accept & ex_in.req_sent;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
    end else if (flush) begin
      mem_valid <= 1'b0;
    end else if (mem_allowin) begin
      mem_valid <= ex_mem_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur <= '0;
    end else if (accept && !flush) begin
      cur <= ex_in;
    end
  end

  // A request whose instruction gets flushed still owes one data_ok, hence DISCARD.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      rdata_buf <= 32'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_req) state <= flush ? ST_DISCARD : ST_WAIT;
        end
        ST_WAIT: begin
          if (data_sram_data_ok) begin
            if (flush) begin
              state <= take_req ? ST_DISCARD : ST_IDLE;
            end else if (wb_allowin) begin
              state <= take_req ? ST_WAIT : ST_IDLE;
            end else begin
              state     <= ST_HOLD;
              rdata_buf <= data_sram_rdata;
            end
          end else if (flush) begin
            state <= ST_DISCARD;
          end
        end
        ST_HOLD: begin
          if (flush) begin
            state     <= take_req ? ST_DISCARD : ST_IDLE;
            rdata_buf <= 32'b0;
          end else if (wb_allowin) begin
            state <= take_req ? ST_WAIT : ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (data_sram_data_ok) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ld_src      = (state == ST_HOLD) ? rdata_buf : data_sram_rdata;
  assign cur_is_load = is_load(cur.ld_op);

  mem_load_ext u_load_ext (
    .ld_op  (cur.ld_op),
    .addr   (cur.alu_result[1:0]),
    .rdata  (ld_src),
    .result (load_val)
  );

  assign final_result = cur_is_load ? load_val : cur.alu_result;

  always_comb begin
    wb              = '0;
    wb.gr_we        = cur.gr_we;
    wb.pc           = cur.pc;
    wb.inst         = cur.inst;
    wb.final_result = final_result;
    wb.dest         = cur.dest;
    wb.csr_we       = cur.csr_we;
    wb.csr_re       = cur.csr_re;
    wb.csr_num      = cur.csr_num;
    wb.csr_wmask    = cur.csr_wmask;
    wb.csr_wvalue   = cur.csr_wvalue;
    wb.ertn         = cur.ertn;
    wb.syscall      = cur.syscall;
  end

  always_comb begin
    id              = '0;
    id.rf_we        = mem_valid & cur.gr_we;
    id.dest         = cur.dest;
    id.result       = final_result;
    id.load_pending = mem_valid & cur_is_load & ~mem_ready_go;
    id.csr_re       = mem_valid & cur.csr_re;
  end

  assign mem_wb_bus   = wb;
  assign mem_id_bus   = id;
  assign mem_ex_block = mem_valid & (cur.ertn | cur.syscall);
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed corner cases plus randomized traffic against a
// transaction-level model that predicts each MEM->WB bus from the instruction and its load data.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ex_mem_valid;
  logic [187:0] ex_mem_bus;
  logic         mem_allowin;
  logic         wb_allowin;
  logic         mem_wb_valid;
  logic [183:0] mem_wb_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic [39:0]  mem_id_bus;
  logic         mem_ex_block;
  logic [1:0]   dbg_state;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_bus        (ex_mem_bus),
    .mem_allowin       (mem_allowin),
    .wb_allowin        (wb_allowin),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_bus        (mem_wb_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .mem_id_bus        (mem_id_bus),
    .mem_ex_block      (mem_ex_block),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ld_op;
    logic        req_sent;
    logic        gr_we;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        ertn;
    logic        syscall;
  } instr_t;

  int total = 0;
  int bad   = 0;
  logic [183:0] exp_q[$];

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [183:0] got, input logic [183:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [187:0] pack_ex(input instr_t t);
    return {t.ld_op, t.req_sent, t.gr_we, t.pc, t.inst, t.alu, t.dest, t.csr_we, t.csr_re,
            t.csr_num, t.wmask, t.wvalue, t.ertn, t.syscall};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int unsigned sh;
    sh = 32'(addr[1:0]) * 8;
    v  = addr;
    case (op)
      3'd1, 3'd4: begin
        v = (rd >> sh) & 32'hFF;
        if (op == 3'd1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'd2, 3'd5: begin
        sh = 32'(addr[1]) * 16;
        v  = (rd >> sh) & 32'hFFFF;
        if (op == 3'd2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      3'd3: v = rd;
      default: v = addr;
    endcase
    return v;
  endfunction

  function automatic logic [183:0] exp_wb(input instr_t t, input logic [31:0] rd);
    logic [31:0] fin;
    fin = (t.ld_op >= 3'd1 && t.ld_op <= 3'd5) ? model_load(t.ld_op, t.alu, rd) : t.alu;
    return {t.gr_we, t.pc, t.inst, fin, t.dest, t.csr_we, t.csr_re, t.csr_num,
            t.wmask, t.wvalue, t.ertn, t.syscall};
  endfunction

  function automatic logic [31:0] wb_result(input logic [183:0] b);
    return b[118:87];
  endfunction

  // ---------------- stimulus generators ----------------
  function automatic instr_t mk(input logic [2:0] op, input logic [31:0] alu);
    instr_t t;
    t.ld_op    = op;
    t.req_sent = (op >= 3'd1 && op <= 3'd6);
    t.gr_we    = (op != 3'd6);
    t.pc       = $urandom;
    t.inst     = $urandom;
    t.alu      = alu;
    t.dest     = 5'($urandom_range(1, 31));
    t.csr_we   = 1'b0;
    t.csr_re   = 1'b0;
    t.csr_num  = 14'b0;
    t.wmask    = 32'b0;
    t.wvalue   = 32'b0;
    t.ertn     = 1'b0;
    t.syscall  = 1'b0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    logic [31:0] a;
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    a  = $urandom;
    if (op == 3'd2 || op == 3'd5) a[0] = 1'b0;
    if (op == 3'd3) a[1:0] = 2'b00;
    t = mk(op, a);
    t.gr_we   = 1'($urandom_range(0, 1));
    t.csr_we  = 1'($urandom_range(0, 1));
    t.csr_re  = 1'($urandom_range(0, 1));
    t.csr_num = 14'($urandom);
    t.wmask   = $urandom;
    t.wvalue  = $urandom;
    t.ertn    = ($urandom_range(0, 7) == 0);
    t.syscall = ($urandom_range(0, 7) == 0);
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic present(input instr_t t);
    ex_mem_valid = 1'b1;
    ex_mem_bus   = pack_ex(t);
  endtask

  task automatic directed_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] rd, input logic [31:0] expv);
    instr_t t;
    @(negedge clk);
    t = mk(op, addr);
    present(t);
    wb_allowin = 1'b1;
    #1;
    @(negedge clk);
    ex_mem_valid      = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    #1;
    check({tag, "_valid"}, 184'(mem_wb_valid), 184'(1));
    check({tag, "_result"}, 184'(wb_result(mem_wb_bus)), 184'(expv));
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
  endtask

  // Random traffic with an SRAM responder that answers each issued request after 0-3 cycles.
  instr_t      pend_t;
  logic        have = 1'b0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_rd;

  task automatic rand_cycle(input bit gen, input bit wb_always);
    logic [183:0] e;
    logic [31:0]  rd;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
    if (pend) begin
      if (pend_cnt == 0) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = pend_rd;
        pend              = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (gen && !have && $urandom_range(0, 2) != 0) begin
      pend_t = rand_instr();
      have   = 1'b1;
    end
    ex_mem_valid = have;
    if (have) ex_mem_bus = pack_ex(pend_t);
    wb_allowin = wb_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    if (mem_wb_valid && wb_allowin) begin
      if (exp_q.size() == 0) begin
        check("rnd_spurious", 184'(mem_wb_valid), 184'(0));
      end else begin
        e = exp_q.pop_front();
        check("rnd_wb_bus", mem_wb_bus, e);
        check("rnd_id_result", 184'(mem_id_bus[33:2]), 184'(wb_result(e)));
      end
    end
    if (have && mem_allowin) begin
      rd = $urandom;
      if (pend_t.req_sent) begin
        pend     = 1'b1;
        pend_cnt = $urandom_range(0, 3);
        pend_rd  = rd;
      end
      exp_q.push_back(exp_wb(pend_t, rd));
      have = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  instr_t t;

  initial begin
    resetn            = 1'b0;
    ex_mem_valid      = 1'b0;
    ex_mem_bus        = '0;
    wb_allowin        = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'b0;
    flush             = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_allowin", 184'(mem_allowin), 184'(1));
    check("rst_wb_valid", 184'(mem_wb_valid), 184'(0));
    check("rst_wb_bus", mem_wb_bus, 184'(0));
    check("rst_id_bus", 184'(mem_id_bus), 184'(0));
    check("rst_ex_block", 184'(mem_ex_block), 184'(0));
    check("rst_state", 184'(dbg_state), 184'(0));
    @(negedge clk);
    resetn = 1'b1;

    // plain ALU instruction: one cycle through MEM
    @(negedge clk);
    t = mk(3'd0, 32'h1234_5678);
    present(t);
    wb_allowin = 1'b1;
    #1;
    check("add_allowin", 184'(mem_allowin), 184'(1));
    check("add_not_yet", 184'(mem_wb_valid), 184'(0));
    @(negedge clk);
    ex_mem_valid = 1'b0;
    #1;
    check("add_valid", 184'(mem_wb_valid), 184'(1));
    check("add_bus", mem_wb_bus, exp_wb(t, 32'b0));
    check("add_rf_we", 184'(mem_id_bus[39]), 184'(1));
    @(negedge clk);
    #1;
    check("add_gone", 184'(mem_wb_valid), 184'(0));

    // extension corner cases with data in the first MEM cycle
    directed_load("ldb", 3'd1, 32'h1000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
    directed_load("ldbu", 3'd4, 32'h1000_0003, 32'h80FF_1234, 32'h0000_0080);
    directed_load("ldh", 3'd2, 32'h1000_0002, 32'h80FF_1234, 32'hFFFF_80FF);
    directed_load("ldhu", 3'd5, 32'h1000_0000, 32'h80FF_9234, 32'h0000_9234);
    directed_load("ldb1", 3'd1, 32'h1000_0001, 32'h80FF_1234, 32'h0000_0012);

    // ld.w with a 3-cycle response delay
    @(negedge clk);
    t = mk(3'd3, 32'h2000_0000);
    present(t);
    #1;
    @(negedge clk);
    ex_mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ldw_wait_allowin", 184'(mem_allowin), 184'(0));
      check("ldw_wait_pending", 184'(mem_id_bus[1]), 184'(1));
      check("ldw_wait_wbv", 184'(mem_wb_valid), 184'(0));
      @(negedge clk);
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    #1;
    check("ldw_valid", 184'(mem_wb_valid), 184'(1));
    check("ldw_result", 184'(wb_result(mem_wb_bus)), 184'(32'hCAFE_F00D));
    check("ldw_pending_clr", 184'(mem_id_bus[1]), 184'(0));
    @(negedge clk);
    data_sram_data_ok = 1'b0;

    // response arrives while WB is stalled: buffered and delivered later
    @(negedge clk);
    t = mk(3'd3, 32'h3000_0004);
    present(t);
    wb_allowin = 1'b1;
    #1;
    @(negedge clk);
    ex_mem_valid      = 1'b0;
    wb_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1357_9BDF;
    #1;
    check("hold_c1_wbv", 184'(mem_wb_valid), 184'(1));
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("hold_state", 184'(dbg_state), 184'(2));
    check("hold_c2_wbv", 184'(mem_wb_valid), 184'(1));
    check("hold_c2_allowin", 184'(mem_allowin), 184'(0));
    @(negedge clk);
    wb_allowin = 1'b1;
    #1;
    check("hold_c3_wbv", 184'(mem_wb_valid), 184'(1));
    check("hold_c3_result", 184'(wb_result(mem_wb_bus)), 184'(32'h1357_9BDF));
    check("hold_c3_allowin", 184'(mem_allowin), 184'(1));
    @(negedge clk);
    #1;
    check("hold_done_wbv", 184'(mem_wb_valid), 184'(0));
    check("hold_done_state", 184'(dbg_state), 184'(0));

    // flush while waiting: the late response must be swallowed
    @(negedge clk);
    t = mk(3'd1, 32'h4000_0001);
    present(t);
    #1;
    @(negedge clk);
    ex_mem_valid = 1'b0;
    flush        = 1'b1;
    #1;
    check("flw_wbv", 184'(mem_wb_valid), 184'(0));
    @(negedge clk);
    flush = 1'b0;
    t = mk(3'd0, 32'h5555_AAAA);
    present(t);
    #1;
    check("flw_state", 184'(dbg_state), 184'(3));
    check("flw_allowin1", 184'(mem_allowin), 184'(0));
    check("flw_wbv1", 184'(mem_wb_valid), 184'(0));
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h7777_7777;
    #1;
    check("flw_allowin2", 184'(mem_allowin), 184'(0));
    check("flw_wbv2", 184'(mem_wb_valid), 184'(0));
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    check("flw_idle_state", 184'(dbg_state), 184'(0));
    check("flw_idle_allowin", 184'(mem_allowin), 184'(1));
    check("flw_idle_wbv", 184'(mem_wb_valid), 184'(0));
    @(negedge clk);
    ex_mem_valid = 1'b0;
    #1;
    check("flw_next_wbv", 184'(mem_wb_valid), 184'(1));
    check("flw_next_bus", mem_wb_bus, exp_wb(t, 32'b0));

    // flush and data_ok in the same cycle: straight back to IDLE
    @(negedge clk);
    t = mk(3'd3, 32'h6000_0008);
    present(t);
    #1;
    @(negedge clk);
    ex_mem_valid      = 1'b0;
    flush             = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h2468_ACE0;
    #1;
    check("fdo_wbv", 184'(mem_wb_valid), 184'(0));
    @(negedge clk);
    flush             = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    check("fdo_state", 184'(dbg_state), 184'(0));
    check("fdo_allowin", 184'(mem_allowin), 184'(1));
    check("fdo_wbv2", 184'(mem_wb_valid), 184'(0));

    // syscall in MEM blocks EX stores
    @(negedge clk);
    t = mk(3'd0, 32'h0);
    t.syscall = 1'b1;
    present(t);
    wb_allowin = 1'b0;
    #1;
    @(negedge clk);
    ex_mem_valid = 1'b0;
    #1;
    check("sys_block", 184'(mem_ex_block), 184'(1));
    @(negedge clk);
    wb_allowin = 1'b1;
    #1;
    @(negedge clk);
    #1;
    check("sys_unblock", 184'(mem_ex_block), 184'(0));

    // asynchronous reset in the middle of a wait
    @(negedge clk);
    t = mk(3'd3, 32'h7000_0000);
    present(t);
    #1;
    @(negedge clk);
    ex_mem_valid = 1'b0;
    #1;
    check("rstw_state_wait", 184'(dbg_state), 184'(1));
    resetn = 1'b0;
    #1;
    check("rstw_state", 184'(dbg_state), 184'(0));
    check("rstw_allowin", 184'(mem_allowin), 184'(1));
    check("rstw_wbv", 184'(mem_wb_valid), 184'(0));
    @(negedge clk);
    resetn = 1'b1;

    // randomized traffic, then drain
    for (int c = 0; c < 800; c++) rand_cycle(1'b1, 1'b0);
    for (int c = 0; c < 30; c++) rand_cycle(1'b0, 1'b1);
    check("rnd_drain_empty", 184'(exp_q.size()), 184'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
